// File: rtl/lsu_bg_rr_crossbar_if.sv
// LSU <-> bank-group crossbar bus: write/read request handshakes from the LSU
// array plus the registered bank-group side and the read-return path.
interface lsu_bg_rr_crossbar_if #(
  parameter int N_LSU = 4,
  parameter int N_BG  = 4,
  parameter int A_W   = 10,
  parameter int D_W   = 32
);
  localparam int SEL_W = (N_BG > 1) ? $clog2(N_BG) : 1;

  logic [N_LSU-1:0]       w_valid;
  logic [N_LSU*SEL_W-1:0] w_sel;
  logic [N_LSU*A_W-1:0]   w_addr;
  logic [N_LSU*D_W-1:0]   w_data;
  logic [N_LSU-1:0]       w_ready;
  logic [N_LSU-1:0]       r_valid;
  logic [N_LSU*A_W-1:0]   r_addr;
  logic [N_LSU-1:0]       r_ready;
  logic [N_BG*D_W-1:0]    bg_rdata;
  logic [N_BG-1:0]        bg_wen;
  logic [N_BG-1:0]        bg_ren;
  logic [N_BG*A_W-1:0]    bg_addr;
  logic [N_BG*D_W-1:0]    bg_wdata;
  logic [N_LSU-1:0]       lsu_rvalid;
  logic [N_LSU*D_W-1:0]   lsu_rdata;
  logic                   err_sel;

  // Crossbar side
  modport slave (
    input  w_valid, w_sel, w_addr, w_data, r_valid, r_addr, bg_rdata,
    output w_ready, r_ready, bg_wen, bg_ren, bg_addr, bg_wdata,
           lsu_rvalid, lsu_rdata, err_sel
  );

  // LSU array / bank model side
  modport master (
    output w_valid, w_sel, w_addr, w_data, r_valid, r_addr, bg_rdata,
    input  w_ready, r_ready, bg_wen, bg_ren, bg_addr, bg_wdata,
           lsu_rvalid, lsu_rdata, err_sel
  );
endinterface

// File: rtl/lsu_bg_rr_crossbar.sv
// LSU -> bank-group write crossbar with per-bank round-robin arbitration,
// read-over-write priority with a starvation guard, and registered bank ports.
// Reads are one-to-one (LSU i <-> BG i), so N_LSU must equal N_BG.

// One bank group: RR write arbiter, starvation counter, output registers.
module lsu_bg_rr_bank #(
  parameter int N_LSU      = 4,
  parameter int A_W        = 10,
  parameter int D_W        = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_LSU-1:0]           cand,
  input  logic [N_LSU-1:0][A_W-1:0]  w_addr,
  input  logic [N_LSU-1:0][D_W-1:0]  w_data,
  input  logic                       r_valid,
  input  logic [A_W-1:0]             r_addr,
  output logic [N_LSU-1:0]           gnt,
  output logic                       r_ready,
  output logic                       bg_wen,
  output logic                       bg_ren,
  output logic [A_W-1:0]             bg_addr,
  output logic [D_W-1:0]             bg_wdata,
  output logic                       lsu_rvalid
);
  localparam int PTR_W = (N_LSU > 1) ? $clog2(N_LSU) : 1;

  logic [PTR_W-1:0] ptr;
  logic [3:0]       cnt;
  logic [PTR_W-1:0] pick;
  logic             has_cand;
  logic             rd_win;
  logic             wr_en;
  logic             rd_go;

  // First candidate at or after ptr, wrapping modulo N_LSU
  always_comb begin
    int idx;
    pick     = '0;
    has_cand = 1'b0;
    for (int o = 0; o < N_LSU; o++) begin
      idx = int'(ptr) + o;
      if (idx >= N_LSU) idx = idx - N_LSU;
      if (!has_cand && cand[idx]) begin
        has_cand = 1'b1;
        pick     = PTR_W'(idx);
      end
    end
  end

  // A read wins unless the counter has hit the limit; then a waiting write goes
  assign rd_win = r_valid && (cnt < 4'(STARVE_LIM));
  assign wr_en  = has_cand && !rd_win;
  assign rd_go  = r_valid && !wr_en;

  // Handshakes are held low while reset is asserted
  always_comb begin
    gnt = '0;
    if (wr_en && rst_n) gnt[pick] = 1'b1;
  end
  assign r_ready = rd_go && rst_n;

  // RR pointer advances past the granted LSU; counter tracks blocked writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (wr_en) begin
      ptr <= (pick == PTR_W'(N_LSU - 1)) ? '0 : pick + 1'b1;
      cnt <= '0;
    end else if (has_cand && rd_go && (cnt < 4'(STARVE_LIM))) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Registered bank-side command; read return valid trails bg_ren by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_wen     <= 1'b0;
      bg_ren     <= 1'b0;
      bg_addr    <= '0;
      bg_wdata   <= '0;
      lsu_rvalid <= 1'b0;
    end else begin
      bg_wen     <= wr_en;
      bg_ren     <= rd_go;
      bg_addr    <= rd_go ? r_addr : (wr_en ? w_addr[pick] : '0);
      bg_wdata   <= wr_en ? w_data[pick] : '0;
      lsu_rvalid <= bg_ren;
    end
  end
endmodule

module lsu_bg_rr_crossbar #(
  parameter int N_LSU      = 4,
  parameter int N_BG       = 4,
  parameter int A_W        = 10,
  parameter int D_W        = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lsu_bg_rr_crossbar_if.slave  bus
);
  localparam int SEL_W = (N_BG > 1) ? $clog2(N_BG) : 1;

  logic [N_LSU-1:0][SEL_W-1:0] sel;
  logic [N_LSU-1:0][A_W-1:0]   waddr;
  logic [N_LSU-1:0][D_W-1:0]   wdata;
  logic [N_BG-1:0][A_W-1:0]    raddr;
  logic [N_BG-1:0][N_LSU-1:0]  cand;
  logic [N_BG-1:0][N_LSU-1:0]  gnt;
  logic [N_LSU-1:0]            bad_sel;
  logic [N_LSU-1:0]            wr_rdy;
  logic [N_BG-1:0]             rd_rdy;
  logic [N_BG-1:0]             wen;
  logic [N_BG-1:0]             ren;
  logic [N_BG-1:0]             rvld;
  logic [N_BG-1:0][A_W-1:0]    baddr;
  logic [N_BG-1:0][D_W-1:0]    bwdata;
  logic                        err_q;

  assign sel   = bus.w_sel;
  assign waddr = bus.w_addr;
  assign wdata = bus.w_data;
  assign raddr = bus.r_addr;

  // Route each valid request to the candidate set of its target bank;
  // an out-of-range select lands in no set and is flagged instead
  always_comb begin
    cand    = '0;
    bad_sel = '0;
    for (int i = 0; i < N_LSU; i++) begin
      bad_sel[i] = bus.w_valid[i] && (32'(sel[i]) >= 32'(N_BG));
      for (int j = 0; j < N_BG; j++)
        cand[j][i] = bus.w_valid[i] && (32'(sel[i]) == 32'(j));
    end
  end

  for (genvar j = 0; j < N_BG; j++) begin : g_bank
    lsu_bg_rr_bank #(
      .N_LSU(N_LSU), .A_W(A_W), .D_W(D_W), .STARVE_LIM(STARVE_LIM)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .cand       (cand[j]),
      .w_addr     (waddr),
      .w_data     (wdata),
      .r_valid    (bus.r_valid[j]),
      .r_addr     (raddr[j]),
      .gnt        (gnt[j]),
      .r_ready    (rd_rdy[j]),
      .bg_wen     (wen[j]),
      .bg_ren     (ren[j]),
      .bg_addr    (baddr[j]),
      .bg_wdata   (bwdata[j]),
      .lsu_rvalid (rvld[j])
    );
  end

  // Each LSU sits in at most one candidate set, so OR-ing grants is exact
  always_comb begin
    wr_rdy = '0;
    for (int j = 0; j < N_BG; j++) wr_rdy = wr_rdy | gnt[j];
  end

  // Sticky bad-select flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (|bad_sel) err_q <= 1'b1;
  end

  assign bus.w_ready    = wr_rdy;
  assign bus.r_ready    = rd_rdy;
  assign bus.bg_wen     = wen;
  assign bus.bg_ren     = ren;
  assign bus.bg_addr    = baddr;
  assign bus.bg_wdata   = bwdata;
  assign bus.lsu_rvalid = rvld;
  assign bus.lsu_rdata  = bus.bg_rdata;
  assign bus.err_sel    = err_q;
endmodule

// File: tb/tb_lsu_bg_rr_crossbar.sv
// Randomized bench for lsu_bg_rr_crossbar against a per-bank arbitration model,
// with directed scenarios for single write, contention, starvation, read return,
// parallel writes, bad select (3-bank instance) and mid-operation reset.
module tb_lsu_bg_rr_crossbar;
  localparam int N   = 4;
  localparam int A_W = 10;
  localparam int D_W = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bg_rr_crossbar_if #(.N_LSU(N), .N_BG(N), .A_W(A_W), .D_W(D_W)) bus ();
  lsu_bg_rr_crossbar_if #(.N_LSU(3), .N_BG(3), .A_W(A_W), .D_W(D_W)) bus3 ();

  lsu_bg_rr_crossbar #(.N_LSU(N), .N_BG(N), .A_W(A_W), .D_W(D_W), .STARVE_LIM(LIM))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  lsu_bg_rr_crossbar #(.N_LSU(3), .N_BG(3), .A_W(A_W), .D_W(D_W), .STARVE_LIM(LIM))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks = 0;
  int failures = 0;

  // stimulus
  logic [N-1:0]     wv, rv;
  int               wsel [N];
  logic [A_W-1:0]   wa [N], ra [N];
  logic [D_W-1:0]   wd [N];
  logic [N*D_W-1:0] rdat;

  // reference model: per-bank RR pointer, blocked-write count, expected outputs
  int             mptr [N], mcnt [N], n_ptr [N], n_cnt [N];
  logic [N-1:0]   m_wr, m_rr;
  logic [N-1:0]   e_wen, e_ren, e_rv, n_wen, n_ren;
  logic [A_W-1:0] e_addr [N], n_addr [N];
  logic [D_W-1:0] e_wd [N], n_wd [N];
  logic [D_W-1:0] par_wd [N];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.w_valid[i]          = wv[i];
      bus.w_sel[i*2 +: 2]     = 2'(wsel[i]);
      bus.w_addr[i*A_W +: A_W] = wa[i];
      bus.w_data[i*D_W +: D_W] = wd[i];
      bus.r_valid[i]          = rv[i];
      bus.r_addr[i*A_W +: A_W] = ra[i];
    end
    bus.bg_rdata = rdat;
  endtask

  task automatic clear_req();
    wv = '0; rv = '0;
    for (int i = 0; i < N; i++) begin
      wsel[i] = 0; wa[i] = '0; ra[i] = '0; wd[i] = '0;
    end
  endtask

  task automatic model_reset();
    e_wen = '0; e_ren = '0; e_rv = '0;
    for (int j = 0; j < N; j++) begin
      mptr[j] = 0; mcnt[j] = 0; e_addr[j] = '0; e_wd[j] = '0;
    end
  endtask

  // At the falling edge: predict this cycle's handshakes, check everything,
  // and compute the state/outputs the next rising edge should produce.
  task automatic cyc_check();
    int k, i;
    @(negedge clk);
    m_wr = '0; m_rr = '0;
    for (int j = 0; j < N; j++) begin
      k = -1;
      for (int o = 0; o < N; o++) begin
        i = (mptr[j] + o) % N;
        if (k < 0 && wv[i] && wsel[i] == j) k = i;
      end
      n_ptr[j] = mptr[j]; n_cnt[j] = mcnt[j];
      n_wen[j] = 1'b0; n_ren[j] = 1'b0; n_addr[j] = '0; n_wd[j] = '0;
      if (rv[j] && mcnt[j] < LIM) begin
        m_rr[j] = 1'b1; n_ren[j] = 1'b1; n_addr[j] = ra[j];
        if (k >= 0) n_cnt[j] = (mcnt[j] + 1 > LIM) ? LIM : mcnt[j] + 1;
      end else if (k >= 0) begin
        m_wr[k] = 1'b1; n_wen[j] = 1'b1; n_addr[j] = wa[k]; n_wd[j] = wd[k];
        n_ptr[j] = (k + 1) % N; n_cnt[j] = 0;
      end else if (rv[j]) begin
        m_rr[j] = 1'b1; n_ren[j] = 1'b1; n_addr[j] = ra[j];
      end
    end
    chk("w_ready", bus.w_ready, m_wr);
    chk("r_ready", bus.r_ready, m_rr);
    chk("bg_wen", bus.bg_wen, e_wen);
    chk("bg_ren", bus.bg_ren, e_ren);
    chk("wen_and_ren", bus.bg_wen & bus.bg_ren, '0);
    for (int j = 0; j < N; j++) begin
      chk("bg_addr", bus.bg_addr[j*A_W +: A_W], e_addr[j]);
      chk("bg_wdata", bus.bg_wdata[j*D_W +: D_W], e_wd[j]);
    end
    chk("lsu_rvalid", bus.lsu_rvalid, e_rv);
    chk("lsu_rdata", bus.lsu_rdata, rdat);
    chk("err_sel", bus.err_sel, 1'b0);
  endtask

  task automatic cyc_adv();
    @(posedge clk);
    #1;
    e_rv = e_ren; e_wen = n_wen; e_ren = n_ren;
    e_addr = n_addr; e_wd = n_wd; mptr = n_ptr; mcnt = n_cnt;
    rdat = {$urandom, $urandom, $urandom, $urandom};
    drive();
  endtask

  initial begin
    logic [N-1:0] exp_seq [5];
    logic [5:0]   rr_pat, wr_pat;
    clear_req();
    rdat = '0;
    drive();
    bus3.w_valid = '0; bus3.w_sel = '0; bus3.w_addr = '0; bus3.w_data = '0;
    bus3.r_valid = '0; bus3.r_addr = '0; bus3.bg_rdata = '0;
    model_reset();

    // reset state: outputs low, handshakes gated even with requests pending
    wv = '1; rv = '1; drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_w_ready", bus.w_ready, '0);
    chk("rst_r_ready", bus.r_ready, '0);
    chk("rst_bg_wen", bus.bg_wen, '0);
    chk("rst_bg_ren", bus.bg_ren, '0);
    chk("rst_bg_addr", bus.bg_addr, '0);
    chk("rst_bg_wdata", bus.bg_wdata, '0);
    chk("rst_lsu_rvalid", bus.lsu_rvalid, '0);
    chk("rst_err_sel", bus.err_sel, 1'b0);
    @(posedge clk); #1;
    clear_req(); drive();
    rst_n = 1'b1;

    // single write: LSU2 -> BG1
    wv[2] = 1'b1; wsel[2] = 1; wa[2] = 10'h005; wd[2] = 32'hDEADBEEF; drive();
    // 3-bank instance: LSU0 selects nonexistent bank 3, LSU1 writes bank 2
    bus3.w_valid = 3'b011; bus3.w_sel = {2'd0, 2'd2, 2'd3};
    cyc_check();
    chk("sw_w_ready2", bus.w_ready[2], 1'b1);
    chk("bad_sel_w_ready", bus3.w_ready, 3'b010);
    cyc_adv();
    clear_req(); drive();
    bus3.w_valid = '0;
    cyc_check();
    chk("sw_bg_wen", bus.bg_wen, 4'b0010);
    chk("sw_addr", bus.bg_addr[1*A_W +: A_W], 10'h005);
    chk("sw_data", bus.bg_wdata[1*D_W +: D_W], 32'hDEADBEEF);
    chk("bad_sel_err", bus3.err_sel, 1'b1);
    chk("bad_sel_bg_wen", bus3.bg_wen, 3'b100);
    cyc_adv();

    // contention: all LSUs hammer BG3
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < N; i++) begin
      wv[i] = 1'b1; wsel[i] = 3; wa[i] = A_W'(i + 16); wd[i] = 32'hC0DE0000 + D_W'(i);
    end
    drive();
    for (int c = 0; c < 5; c++) begin
      cyc_check();
      chk("cont_grant", bus.w_ready, exp_seq[c]);
      cyc_adv();
    end
    clear_req(); drive();
    cyc_check(); cyc_adv();

    // starvation guard: read held on BG0 while LSU1 keeps writing BG0
    rr_pat = 6'b101111; wr_pat = 6'b010000;
    rv[0] = 1'b1; ra[0] = 10'h0AA;
    wv[1] = 1'b1; wsel[1] = 0; wa[1] = 10'h055; wd[1] = 32'h5A5A5A5A;
    drive();
    for (int c = 0; c < 6; c++) begin
      cyc_check();
      chk("starve_r_ready0", bus.r_ready[0], rr_pat[c]);
      chk("starve_w_ready1", bus.w_ready[1], wr_pat[c]);
      cyc_adv();
    end
    clear_req(); drive();
    cyc_check(); cyc_adv();
    cyc_check(); cyc_adv();

    // read data path on BG3
    rv[3] = 1'b1; ra[3] = 10'h3FF; drive();
    cyc_check();
    chk("rd_r_ready3", bus.r_ready[3], 1'b1);
    cyc_adv();
    clear_req(); drive();
    cyc_check();
    chk("rd_bg_ren3", bus.bg_ren[3], 1'b1);
    chk("rd_bg_addr3", bus.bg_addr[3*A_W +: A_W], 10'h3FF);
    cyc_adv();
    rdat[3*D_W +: D_W] = 32'h12345678; drive();
    cyc_check();
    chk("rd_lsu_rvalid3", bus.lsu_rvalid[3], 1'b1);
    chk("rd_lsu_rdata3", bus.lsu_rdata[3*D_W +: D_W], 32'h12345678);
    cyc_adv();

    // parallel independence: LSU i -> BG 3-i
    for (int i = 0; i < N; i++) begin
      wv[i] = 1'b1; wsel[i] = 3 - i; wa[i] = A_W'($urandom); wd[i] = $urandom;
      par_wd[i] = wd[i];
    end
    drive();
    cyc_check();
    chk("par_w_ready", bus.w_ready, 4'b1111);
    cyc_adv();
    clear_req(); drive();
    cyc_check();
    chk("par_bg_wen", bus.bg_wen, 4'b1111);
    for (int j = 0; j < N; j++) chk("par_data", bus.bg_wdata[j*D_W +: D_W], par_wd[3-j]);
    cyc_adv();

    // randomized traffic; ungranted requests are held stable
    for (int c = 0; c < 500; c++) begin
      cyc_check();
      for (int i = 0; i < N; i++) begin
        if (m_wr[i] || !wv[i]) begin
          wv[i] = ($urandom % 3) != 0;
          wsel[i] = (c % 64 < 16) ? 2 : int'($urandom % 4);
          wa[i] = A_W'($urandom); wd[i] = $urandom;
        end
        if (m_rr[i] || !rv[i]) begin
          rv[i] = ($urandom % 2) != 0;
          ra[i] = A_W'($urandom);
        end
      end
      cyc_adv();
    end
    clear_req(); drive();
    cyc_check(); cyc_adv();

    // reset mid-operation while all banks are reading
    rv = '1;
    for (int i = 0; i < N; i++) ra[i] = A_W'($urandom);
    drive();
    cyc_check(); cyc_adv();
    #2;
    chk("pre_rst_bg_ren", bus.bg_ren, 4'b1111);
    chk("pre_rst_err3", bus3.err_sel, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bg_ren", bus.bg_ren, '0);
    chk("mid_rst_bg_wen", bus.bg_wen, '0);
    chk("mid_rst_bg_addr", bus.bg_addr, '0);
    chk("mid_rst_bg_wdata", bus.bg_wdata, '0);
    chk("mid_rst_lsu_rvalid", bus.lsu_rvalid, '0);
    chk("mid_rst_r_ready", bus.r_ready, '0);
    chk("mid_rst_err3", bus3.err_sel, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_req();
    for (int i = 0; i < N; i++) begin
      wv[i] = 1'b1; wsel[i] = 3; wa[i] = A_W'(i); wd[i] = D_W'(i);
    end
    drive();
    cyc_check();
    chk("post_rst_grant", bus.w_ready, 4'b0001);
    chk("post_rst_lsu_rvalid", bus.lsu_rvalid, '0);
    cyc_adv();
    clear_req(); drive();
    cyc_check(); cyc_adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
